soc_ram_arbiter: RTL

- Two-requester arbiter and sequencer in front of the on-chip SOC RAM macro (registered address/write inputs, read data one cycle later).
- Shares the single RAM port between master 0 (CPU data side) and master 1 (debug/DMA side).
- Arbitration is round-robin, with an optional per-master lock for atomic read-modify-write and a lock timeout.
- Steers RAM read data back to the owner, with a read-valid strobe.

---
 rtl/soc_ram_arbiter_if.sv | 38 +++
 rtl/soc_ram_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/soc_ram_arbiter_if.sv
// Signal bundle between the two RAM requesters, the SOC RAM macro and soc_ram_arbiter.
// The arbiter connects through the slave modport; requesters and the RAM model use master.
interface soc_ram_arbiter_if #(
    parameter int ADDRBIT = 16,
    parameter int DATABIT = 32
);
    logic                 enable;
    logic                 req0, req1;
    logic                 lock0, lock1;
    logic                 wen0, wen1;
    logic [ADDRBIT-1:0]   addr0, addr1;
    logic [DATABIT-1:0]   wdata0, wdata1;
    logic [DATABIT/8-1:0] be0, be1;
    logic                 gnt0, gnt1;
    logic                 rvalid0, rvalid1;
    logic [DATABIT-1:0]   rdata0, rdata1;
    logic                 err0, err1;
    logic [ADDRBIT-1:0]   ram_addr;
    logic [DATABIT-1:0]   ram_w_data;
    logic                 ram_w_en;
    logic [DATABIT/8-1:0] ram_byte_en;
    logic                 ram_bot_active;
    logic [DATABIT-1:0]   ram_r_data;

    modport slave (
        input  enable, req0, req1, lock0, lock1, wen0, wen1,
               addr0, addr1, wdata0, wdata1, be0, be1, ram_r_data,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
               ram_addr, ram_w_data, ram_w_en, ram_byte_en, ram_bot_active
    );

    modport master (
        output enable, req0, req1, lock0, lock1, wen0, wen1,
               addr0, addr1, wdata0, wdata1, be0, be1, ram_r_data,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
               ram_addr, ram_w_data, ram_w_en, ram_byte_en, ram_bot_active
    );
endinterface

// File: rtl/soc_ram_arbiter.sv
// Two-master round-robin arbiter with lock/timeout in front of the SOC RAM port.
// Optional address range checking is compiled in with SOC_RAM_ARB_RANGE_CHECK_EN.
module soc_ram_arbiter #(
    parameter int ADDRBIT    = 16,
    parameter int DATABIT    = 32,
    parameter int LOCK_MAX   = 15,
    parameter int BOTTOMADDR = 0,
    parameter int TOPADDR    = 65535
) (
    input  logic             clk,
    input  logic             rst,
    soc_ram_arbiter_if.slave bus
);
    localparam int                 BEBIT      = DATABIT / 8;
    localparam logic [3:0]         LOCK_MAX_C = 4'(LOCK_MAX);
    localparam logic [DATABIT-1:0] ERR_DATA_C = DATABIT'(32'hBAD0ADD5);

    if (LOCK_MAX > 15) begin : g_bad_lock_max
        $error("LOCK_MAX does not fit the 4-bit lock counter");
    end
    if (TOPADDR < BOTTOMADDR) begin : g_bad_range
        $error("TOPADDR is below BOTTOMADDR");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t             state_r;
    logic               rr_ptr_r;
    logic [3:0]         lock_cnt_r;
    logic               rd0_r, rd1_r;
    logic               err0_r, err1_r;

    logic               go_s;
    logic               gnt0_s, gnt1_s, gnt_any_s, gsel_s;
    logic               glock_s, gwen_s, oor_s;
    logic [ADDRBIT-1:0] gaddr_s;
    logic [DATABIT-1:0] gdata_s;
    logic [BEBIT-1:0]   gbe_s;
    logic [DATABIT-1:0] rdata0_s, rdata1_s;

`ifdef SOC_RAM_ARB_RANGE_CHECK_EN
    function automatic logic addr_out_of_range(input logic [ADDRBIT-1:0] addr);
        int addr_v;
        addr_v = int'(addr);
        return (addr_v < BOTTOMADDR) || (addr_v > TOPADDR);
    endfunction
`endif

    assign go_s = bus.enable & ~rst;

    // Grant decision from ownership state, round-robin pointer and requests.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (go_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req0 && bus.req1) begin
                        if (rr_ptr_r) begin
                            gnt1_s = 1'b1;
                        end else begin
                            gnt0_s = 1'b1;
                        end
                    end else begin
                        gnt0_s = bus.req0;
                        gnt1_s = bus.req1;
                    end
                end
                ST_OWN0: gnt0_s = bus.req0;
                ST_OWN1: gnt1_s = bus.req1;
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Select the winning master's access fields for the shared RAM port.
    always_comb begin
        gnt_any_s = gnt0_s | gnt1_s;
        gsel_s    = gnt1_s;
        if (gnt1_s) begin
            glock_s = bus.lock1;
            gwen_s  = bus.wen1;
            gaddr_s = bus.addr1;
            gdata_s = bus.wdata1;
            gbe_s   = bus.be1;
        end else if (gnt0_s) begin
            glock_s = bus.lock0;
            gwen_s  = bus.wen0;
            gaddr_s = bus.addr0;
            gdata_s = bus.wdata0;
            gbe_s   = bus.be0;
        end else begin
            glock_s = 1'b0;
            gwen_s  = 1'b0;
            gaddr_s = bus.addr0;
            gdata_s = bus.wdata0;
            gbe_s   = {BEBIT{1'b0}};
        end
    end

`ifdef SOC_RAM_ARB_RANGE_CHECK_EN
    assign oor_s = gnt_any_s & addr_out_of_range(gaddr_s);
`else
    assign oor_s = 1'b0;
`endif

    // Ownership FSM: pointer flips after a contended grant, lock holds up to LOCK_MAX+1 grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= 1'b0;
            lock_cnt_r <= 4'd0;
        end else if (bus.enable) begin
            if ((state_r == ST_IDLE) && bus.req0 && bus.req1) begin
                rr_ptr_r <= ~gsel_s;
            end
            if (gnt_any_s && glock_s && (lock_cnt_r < LOCK_MAX_C)) begin
                state_r    <= gsel_s ? ST_OWN1 : ST_OWN0;
                lock_cnt_r <= lock_cnt_r + 4'd1;
            end else begin
                state_r    <= ST_IDLE;
                lock_cnt_r <= 4'd0;
                // A lock that ran out hands the next contended slot to the other master.
                if (gnt_any_s && glock_s) begin
                    rr_ptr_r <= ~gsel_s;
                end
            end
        end
    end

    // Read-return pipeline: remembers which master owns the data arriving next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd0_r  <= 1'b0;
            rd1_r  <= 1'b0;
            err0_r <= 1'b0;
            err1_r <= 1'b0;
        end else begin
            rd0_r  <= gnt0_s & (~gwen_s | oor_s);
            rd1_r  <= gnt1_s & (~gwen_s | oor_s);
            err0_r <= gnt0_s & oor_s;
            err1_r <= gnt1_s & oor_s;
        end
    end

    // Steer RAM read data (or the error pattern) to the owning master only.
    always_comb begin
        rdata0_s = {DATABIT{1'b0}};
        rdata1_s = {DATABIT{1'b0}};
        if (rd0_r) begin
            rdata0_s = err0_r ? ERR_DATA_C : bus.ram_r_data;
        end else begin
            rdata0_s = {DATABIT{1'b0}};
        end
        if (rd1_r) begin
            rdata1_s = err1_r ? ERR_DATA_C : bus.ram_r_data;
        end else begin
            rdata1_s = {DATABIT{1'b0}};
        end
    end

    assign bus.gnt0           = gnt0_s;
    assign bus.gnt1           = gnt1_s;
    assign bus.rvalid0        = rd0_r;
    assign bus.rvalid1        = rd1_r;
    assign bus.err0           = err0_r;
    assign bus.err1           = err1_r;
    assign bus.rdata0         = rdata0_s;
    assign bus.rdata1         = rdata1_s;
    assign bus.ram_addr       = gaddr_s;
    assign bus.ram_w_data     = gdata_s;
    assign bus.ram_w_en       = gwen_s & ~oor_s;
    assign bus.ram_byte_en    = gbe_s;
    assign bus.ram_bot_active = go_s;
endmodule
